// File: rtl/csr_bus_arbiter.sv
// Round-robin arbiter sharing the control-register bus between NUM_REQ requesters.
// Registers the downstream drive, returns read data to its originator, and gates IO accesses around SPI/GPIO activity.
module csr_bus_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IN_reqValid  [NUM_REQ],
    input  logic        IN_reqWe     [NUM_REQ],
    input  logic [3:0]  IN_reqWm     [NUM_REQ],
    input  logic [6:0]  IN_reqAddr   [NUM_REQ],
    input  logic [31:0] IN_reqData   [NUM_REQ],
    output logic        OUT_reqReady [NUM_REQ],
    output logic        OUT_rspValid [NUM_REQ],
    output logic [31:0] OUT_rspData,
    output logic        OUT_ce,
    output logic        OUT_we,
    output logic [3:0]  OUT_wm,
    output logic [6:0]  OUT_addr,
    output logic [31:0] OUT_data,
    input  logic [31:0] IN_data,
    input  logic        IN_IO_busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RD_LAT = 3;

    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic valid;
        idx_t idx;
    } rd_tag_t;

    idx_t               last_grant;
    idx_t               grant_idx;
    idx_t               cand;
    logic               grant_valid;
    logic               accept;
    logic [NUM_REQ-1:0] eligible;
    logic [1:0]         io_hold;
    rd_tag_t            rd_pipe [RD_LAT];

    function automatic logic is_io(input logic [6:0] addr);
        return !addr[5] && (addr[4:2] == 3'b001);
    endfunction

    // Registers 4 and 5 start an SPI/GPIO transfer when written.
    function automatic logic is_io_write(input logic we, input logic [6:0] addr);
        return is_io(addr) && !we && !addr[1];
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = IN_reqValid[i] &&
                          !(is_io(IN_reqAddr[i]) && (io_hold != 2'd0 || IN_IO_busy));
        end
    end

    // NOTE: every variable gets a default before the loop so no path leaves one unassigned (no latch).
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = idx_t'((int'(last_grant) + k) % NUM_REQ);
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // NOTE: reset is synchronous, so combinational outputs are masked by rst themselves during the reset cycle.
    assign accept = grant_valid && !rst;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            OUT_reqReady[i] = accept && (grant_idx == idx_t'(i));
            OUT_rspValid[i] = !rst && rd_pipe[RD_LAT-1].valid &&
                              (rd_pipe[RD_LAT-1].idx == idx_t'(i));
        end
    end

    assign OUT_rspData = IN_data;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= idx_t'(NUM_REQ - 1);
            io_hold    <= 2'd0;
            OUT_ce     <= 1'b1;
            OUT_we     <= 1'b1;
            OUT_wm     <= 4'd0;
            OUT_addr   <= 7'd0;
            OUT_data   <= 32'd0;
            for (int s = 0; s < RD_LAT; s++) begin
                rd_pipe[s] <= '0;
            end
        end else begin
            if (accept) begin
                last_grant <= grant_idx;
                OUT_ce     <= 1'b0;
                OUT_we     <= IN_reqWe[grant_idx];
                OUT_wm     <= IN_reqWm[grant_idx];
                OUT_addr   <= IN_reqAddr[grant_idx];
                OUT_data   <= IN_reqData[grant_idx];
            end else begin
                OUT_ce     <= 1'b1;
            end

            // Covers the gap until the target raises IN_IO_busy for a freshly issued IO write.
            if (accept && is_io_write(IN_reqWe[grant_idx], IN_reqAddr[grant_idx])) begin
                io_hold <= 2'd2;
            end else if (io_hold != 2'd0) begin
                io_hold <= io_hold - 2'd1;
            end

            rd_pipe[0].valid <= accept && IN_reqWe[grant_idx];
            rd_pipe[0].idx   <= grant_idx;
            for (int s = 1; s < RD_LAT; s++) begin
                rd_pipe[s] <= rd_pipe[s-1];
            end
        end
    end

endmodule

// File: tb/tb_csr_bus_arbiter.sv
// Scoreboard bench for csr_bus_arbiter: per-requester request queues drive the ports,
// accepted requests push the expected bus drive and read response, a monitor pops and compares them.
module tb_csr_bus_arbiter;

    localparam int N = 2;

    typedef struct {
        logic        we;
        logic [3:0]  wm;
        logic [6:0]  addr;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        int   cyc;
        txn_t t;
    } bus_exp_t;

    typedef struct {
        int          cyc;
        int          idx;
        logic [31:0] data;
    } rsp_exp_t;

    typedef struct {
        int cyc;
        int idx;
    } grant_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid [N];
    logic        req_we    [N];
    logic [3:0]  req_wm    [N];
    logic [6:0]  req_addr  [N];
    logic [31:0] req_data  [N];
    logic        ready     [N];
    logic        rsp_valid [N];
    logic [31:0] rsp_data;
    logic        bus_ce;
    logic        bus_we;
    logic [3:0]  bus_wm;
    logic [6:0]  bus_addr;
    logic [31:0] bus_data;
    logic [31:0] tgt_data;
    logic        io_busy;

    csr_bus_arbiter #(.NUM_REQ(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .IN_reqValid  (req_valid),
        .IN_reqWe     (req_we),
        .IN_reqWm     (req_wm),
        .IN_reqAddr   (req_addr),
        .IN_reqData   (req_data),
        .OUT_reqReady (ready),
        .OUT_rspValid (rsp_valid),
        .OUT_rspData  (rsp_data),
        .OUT_ce       (bus_ce),
        .OUT_we       (bus_we),
        .OUT_wm       (bus_wm),
        .OUT_addr     (bus_addr),
        .OUT_data     (bus_data),
        .IN_data      (tgt_data),
        .IN_IO_busy   (io_busy)
    );

    always #5 clk = ~clk;

    int       n_checks = 0;
    int       n_fail   = 0;
    int       cyc      = 0;
    bit       mon_en   = 1'b0;
    bit       acc [N];
    logic     busy_force = 1'b0;
    txn_t     cur [N];
    txn_t     rq [N][$];
    bus_exp_t bus_q[$];
    rsp_exp_t rsp_q[$];
    grant_t   glog[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [6:0] a);
        if (a == 7'h21) return 32'hDEADBEEF;
        return 32'hC0DE0000 + 32'(a) * 32'h101;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Target model: read data two cycles after the bus cycle, SPI busy for 64 cycles starting two cycles after an IO write.
    logic       rd_v1 = 1'b0, rd_v2 = 1'b0, io_pend = 1'b0;
    logic [6:0] rd_a1 = '0, rd_a2 = '0;
    int         busy_cnt = 0;

    always @(posedge clk) begin
        rd_v1   <= (bus_ce === 1'b0) && (bus_we === 1'b1);
        rd_a1   <= bus_addr;
        rd_v2   <= rd_v1;
        rd_a2   <= rd_a1;
        io_pend <= (bus_ce === 1'b0) && (bus_we === 1'b0) && !bus_addr[5] && (bus_addr[4:1] == 4'b0010);
        if (io_pend) busy_cnt <= 64;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    assign tgt_data = rd_v2 ? mem_fn(rd_a2) : 32'h0;
    assign io_busy  = busy_force || (busy_cnt != 0);

    // Requester driver: holds the queue head until accepted, then moves on.
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (rq[i].size() > 0) begin
                cur[i]       = rq[i][0];
                req_valid[i] = 1'b1;
                req_we[i]    = cur[i].we;
                req_wm[i]    = cur[i].wm;
                req_addr[i]  = cur[i].addr;
                req_data[i]  = cur[i].data;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    end

    task automatic monitor_cycle();
        int       nready;
        bus_exp_t be;
        rsp_exp_t re;
        grant_t   g;
        nready = 0;

        if (bus_q.size() > 0 && bus_q[0].cyc == cyc) begin
            be = bus_q.pop_front();
            check("bus_ce", bus_ce, 0);
            check("bus_we", bus_we, be.t.we);
            check("bus_wm", bus_wm, be.t.wm);
            check("bus_addr", bus_addr, be.t.addr);
            check("bus_data", bus_data, be.t.data);
        end else begin
            check("bus_idle_ce", bus_ce, 1);
        end

        if (!rst && rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
            re = rsp_q.pop_front();
            for (int i = 0; i < N; i++) check($sformatf("rsp_valid%0d", i), rsp_valid[i], (i == re.idx));
            check("rsp_data", rsp_data, re.data);
        end else begin
            for (int i = 0; i < N; i++) check($sformatf("rsp_quiet%0d", i), rsp_valid[i], 0);
        end

        for (int i = 0; i < N; i++) begin
            acc[i] = req_valid[i] && ready[i];
            if (ready[i] === 1'b1) nready++;
        end
        check("ready_onehot", (nready <= 1), 1);

        if (rst) begin
            for (int i = 0; i < N; i++) check($sformatf("ready_in_rst%0d", i), ready[i], 0);
            bus_q.delete();
            rsp_q.delete();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    be.cyc = cyc + 1;
                    be.t   = cur[i];
                    bus_q.push_back(be);
                    if (cur[i].we) begin
                        re.cyc  = cyc + 3;
                        re.idx  = i;
                        re.data = mem_fn(cur[i].addr);
                        rsp_q.push_back(re);
                    end
                    g.cyc = cyc;
                    g.idx = i;
                    glog.push_back(g);
                end
            end
        end
    endtask

    always begin
        @(negedge clk);
        if (mon_en) monitor_cycle();
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_req(input int i, input logic we, input logic [3:0] wm,
                            input logic [6:0] addr, input logic [31:0] data);
        txn_t t;
        t.we = we; t.wm = wm; t.addr = addr; t.data = data;
        rq[i].push_back(t);
    endtask

    task automatic wait_grants(input int n, input int budget);
        int left;
        left = budget;
        while (glog.size() < n && left > 0) begin
            step();
            left--;
        end
        check("grant_wait_in_budget", (glog.size() >= n), 1);
    endtask

    task automatic wait_idle(input int budget);
        int left;
        bit busy_q;
        left = budget;
        busy_q = 1'b1;
        while (busy_q && left > 0) begin
            step();
            left--;
            busy_q = (rq[0].size() + rq[1].size() + bus_q.size() + rsp_q.size()) != 0;
        end
        check("drain_in_budget", busy_q, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, g0, g1, t_io, p;

        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b1; req_wm[i] = '0;
            req_addr[i] = '0; req_data[i] = '0; acc[i] = 1'b0;
        end

        // Alternating continuous reads, queued while still in reset so ready must stay low.
        for (int k = 0; k < 6; k++) begin
            push_req(0, 1'b1, 4'h0, 7'h00, 32'h0);
            push_req(1, 1'b1, 4'h0, 7'h01, 32'h0);
        end
        step();
        mon_en = 1'b1;
        #1;
        check("rst_ce", bus_ce, 1);
        check("rst_we", bus_we, 1);
        check("rst_wm", bus_wm, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_data", bus_data, 0);
        step();
        rst = 1'b0;
        start = cyc;
        wait_grants(12, 40);
        for (int k = 0; k < 12 && k < glog.size(); k++) begin
            check($sformatf("alt_idx%0d", k), glog[k].idx, k % 2);
            check($sformatf("alt_cyc%0d", k), glog[k].cyc, start + k);
        end
        wait_idle(40);

        // Single read from requester 1 of 0x21.
        g0 = glog.size();
        push_req(1, 1'b1, 4'h0, 7'h21, 32'h0);
        wait_idle(40);
        check("single_rd_idx", (glog.size() > g0) ? glog[g0].idx : -1, 1);

        // Back-to-back IO writes with a non-IO write slipped in during the hold.
        g0 = glog.size();
        push_req(0, 1'b0, 4'hF, 7'h04, 32'hA5000000);
        push_req(0, 1'b0, 4'hF, 7'h04, 32'hA5000000);
        wait_grants(g0 + 1, 20);
        t_io = glog[g0].cyc;
        check("io1_idx", glog[g0].idx, 0);
        push_req(1, 1'b0, 4'h3, 7'h08, 32'h12345678);
        p = cyc;
        wait_grants(g0 + 2, 20);
        check("nonio_idx", glog[g0+1].idx, 1);
        check("nonio_cyc", glog[g0+1].cyc, p + 1);
        wait_grants(g0 + 3, 200);
        check("io2_idx", glog[g0+2].idx, 0);
        check("io2_cyc", glog[g0+2].cyc, t_io + 67);
        wait_idle(40);

        // Reset the cycle after three reads were accepted: no responses may follow.
        g0 = glog.size();
        push_req(0, 1'b1, 4'h0, 7'h02, 32'h0);
        push_req(0, 1'b1, 4'h0, 7'h03, 32'h0);
        push_req(0, 1'b1, 4'h0, 7'h10, 32'h0);
        wait_grants(g0 + 3, 20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("post_rst_ce", bus_ce, 1);
        check("post_rst_addr", bus_addr, 0);
        repeat (6) step();
        g1 = glog.size();
        check("post_rst_no_grant", g1, g0 + 3);
        push_req(0, 1'b1, 4'h0, 7'h09, 32'h0);
        push_req(1, 1'b1, 4'h0, 7'h0A, 32'h0);
        wait_grants(g1 + 2, 20);
        check("post_rst_first", glog[g1].idx, 0);
        check("post_rst_second", glog[g1+1].idx, 1);
        wait_idle(40);

        // Requester 0 withdraws a blocked IO read; the pointer must not move.
        busy_force = 1'b1;
        g0 = glog.size();
        push_req(0, 1'b1, 4'h0, 7'h06, 32'h0);
        repeat (4) step();
        rq[0].delete();
        step();
        busy_force = 1'b0;
        step();
        check("drop_no_grant", glog.size(), g0);
        push_req(0, 1'b1, 4'h0, 7'h0B, 32'h0);
        push_req(1, 1'b1, 4'h0, 7'h0C, 32'h0);
        wait_grants(g0 + 2, 20);
        check("drop_ptr_first", glog[g0].idx, 0);
        wait_idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_bus_arbiter.md
Name: csr_bus_arbiter

Overview:
Shares the single control-register bus (ce/we/wm/addr/data, active-low ce and we) between NUM_REQ requesters, such as the load/store unit and the debug/boot port. It uses round-robin arbitration and registers the downstream drive. It tracks in-flight reads so each read's data returns to its originator. Accesses to IO registers are held back while the SPI or GPIO engines are busy, so back-to-back IO writes never overlap.

Parameters:
NUM_REQ, 2, number of requester ports (2..4)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous reset, active-high
IN_reqValid[NUM_REQ]  in  1 each  requester has a request pending
IN_reqWe[NUM_REQ]  in  1 each  0 = write, 1 = read
IN_reqWm[NUM_REQ]  in  4 each  byte write mask
IN_reqAddr[NUM_REQ]  in  7 each  register address
IN_reqData[NUM_REQ]  in  32 each  write data
OUT_reqReady[NUM_REQ]  out  1 each  grant; the request is accepted when valid && ready
OUT_rspValid[NUM_REQ]  out  1 each  read data valid for this requester (one-cycle pulse)
OUT_rspData  out  32  read data, shared by all requesters
OUT_ce  out  1  downstream chip enable, active-low
OUT_we  out  1  downstream write enable, 0 = write
OUT_wm  out  4  downstream write mask
OUT_addr  out  7  downstream address
OUT_data  out  32  downstream write data
IN_data  in  32  downstream read data
IN_IO_busy  in  1  downstream SPI/GPIO transfer in progress

Behaviour:
- Reset values:
  - OUT_ce=1, OUT_we=1, OUT_wm=0, OUT_addr=0, OUT_data=0.
  - All OUT_rspValid=0 and OUT_reqReady=0 during the rst cycle.
  - Round-robin pointer lastGrant=NUM_REQ-1, so requester 0 has priority first.
  - The read tracking pipe is cleared and ioHold=0.
- Reset mid-operation: in-flight reads are dropped and no response is produced for them.
- IO address: addr[5]==0 && addr[4:0] in {4,5,6,7}.
- IO-write: an IO address with we==0 and addr[4:0] in {4,5}.
- Eligibility:
  - A request is eligible if valid && !(isIO && (ioHold!=0 || IN_IO_busy)).
  - Non-IO requests are never blocked.
- Arbitration (combinational):
  - Scan eligible requesters starting at lastGrant+1 mod NUM_REQ; the first hit is granted.
  - At most one OUT_reqReady is high per cycle.
  - Ready depends only on valid, address, ioHold, IN_IO_busy and the pointer, never on the requester's ready-dependent signals.
- Requester rule: hold addr/data/wm/we stable while valid && !ready. Dropping valid before acceptance is allowed; that request is simply not issued.
- On acceptance in cycle t:
  - lastGrant <= granted index.
  - In cycle t+1: OUT_ce=0 and OUT_we/wm/addr/data equal the accepted request's fields (registered).
  - In a cycle with no acceptance, the following cycle has OUT_ce=1 and the other outputs hold their values.
- Read return:
  - A read accepted in cycle t gives OUT_rspValid[idx]=1 in cycle t+3, with OUT_rspData=IN_data (combinational pass-through).
  - Implemented as a 3-stage shift pipe of {valid, idx}.
  - One read may be accepted every cycle; up to 3 reads are in flight; responses return in acceptance order.
- Writes produce no response.
- Writes to addr[5]==1 are issued unchanged (the target ignores them).
- IO hazard window:
  - On acceptance of an IO-write, ioHold <= 2. Otherwise ioHold decrements while nonzero.
  - This covers the two cycles before the target raises IN_IO_busy. After that, IN_IO_busy alone gates IO accesses.
- Simultaneous events:
  - Acceptance of an IO-write while ioHold!=0 cannot occur, because it is gated.
  - A non-IO grant during the hold window is permitted.
  - Reset takes priority over everything.
- Fairness: a continuously valid, eligible requester is granted within NUM_REQ cycles.

Test Plan:
- Reset, then req0 and req1 both issue reads of addr 0 and addr 1 continuously -> grants alternate 0,1,0,1. OUT_ce=0 every cycle from cycle 1. rspValid[0] in cycles 3, 5, … with data from addr 0; rspValid[1] in cycles 4, 6, … with data from addr 1.
- Single read from req1 of addr 0x21, with the target model returning 0xDEADBEEF -> OUT_rspValid[1]=1 exactly 3 cycles after acceptance, OUT_rspData=0xDEADBEEF, and OUT_rspValid[0] stays 0.
- req0 writes addr 4 with wm=4'b1111 and data 0xA5000000, then immediately writes addr 4 again -> second ready is low for 2 cycles, then stays low while the model holds IN_IO_busy high for 64 cycles; it is accepted on the first cycle IN_IO_busy=0.
- During that IO hold, req1 writes addr 8 (non-IO) -> accepted next cycle; OUT_addr=8, OUT_wm and OUT_data pass through.
- Assert rst one cycle after accepting 3 reads -> no OUT_rspValid pulses afterwards, OUT_ce=1, and req0 is granted first after reset.
- req0 drops valid before it is granted -> nothing issued, OUT_ce stays 1, and the pointer is unchanged.
